fb_write_arbiter: RTL

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// -----------------------------------------------------------------------------
// fb_write_arbiter
//
// Merges two framebuffer write sources onto one registered write port:
//   * single pixel writes (valid/ready handshake)
//   * an inclusive rectangle fill engine (row-major cursor)
// While a fill is running, contended cycles alternate between the two sources
// round-robin. Writes leave on fb_we/fb_addr/fb_data one cycle after their
// grant, so the framebuffer sees them in grant order.
//
// Parameters
//   W  framebuffer width in pixels (power of 2, 2..256)
//   H  framebuffer height in pixels (2..256)
//   B  bits per pixel
//
// Ports
//   clk_in        single clock, all logic on the rising edge
//   rst_in        synchronous active-high reset
//   px_valid      pixel write request
//   px_x, px_y    pixel coordinates (out-of-range pixels are accepted, dropped)
//   px_data       pixel value
//   px_ready      request accepted this cycle when px_valid && px_ready
//   fill_start    start a rectangle fill (sampled only while idle)
//   fill_x0..y1   inclusive rectangle corners, clamped to W-1 / H-1
//   fill_color    fill value
//   fill_busy     fill in progress
//   fill_done     one-cycle completion pulse
//   fb_we         framebuffer write enable (registered)
//   fb_addr       framebuffer address y*W + x (registered, unused MSBs zero)
//   fb_data       framebuffer write data (registered)
// -----------------------------------------------------------------------------
module fb_write_arbiter #(
    parameter int W = 256,
    parameter int H = 256,
    parameter int B = 8
) (
    input  logic         clk_in,
    input  logic         rst_in,

    input  logic         px_valid,
    input  logic [7:0]   px_x,
    input  logic [7:0]   px_y,
    input  logic [B-1:0] px_data,
    output logic         px_ready,

    input  logic         fill_start,
    input  logic [7:0]   fill_x0,
    input  logic [7:0]   fill_y0,
    input  logic [7:0]   fill_x1,
    input  logic [7:0]   fill_y1,
    input  logic [B-1:0] fill_color,
    output logic         fill_busy,
    output logic         fill_done,

    output logic         fb_we,
    output logic [15:0]  fb_addr,
    output logic [B-1:0] fb_data
);

    localparam int         XW    = $clog2(W);
    localparam logic [7:0] X_MAX = 8'(W - 1);
    localparam logic [7:0] Y_MAX = 8'(H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE
    } state_e;

    // Which source won the most recent contended cycle.
    typedef enum logic {
        GNT_FILL,
        GNT_PIX
    } grant_e;

    function automatic logic [7:0] clamp(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // W is a power of two, so y*W + x is a shift and an OR.
    function automatic logic [15:0] addr_of(input logic [7:0] x, input logic [7:0] y);
        return (16'(y) << XW) | 16'(x);
    endfunction

    state_e         state_q,      state_d;
    grant_e         last_gnt_q,   last_gnt_d;
    logic [7:0]     x0_q,         x0_d;
    logic [7:0]     x1_q,         x1_d;
    logic [7:0]     y1_q,         y1_d;
    logic [B-1:0]   color_q,      color_d;
    logic [7:0]     cur_x_q,      cur_x_d;
    logic [7:0]     cur_y_q,      cur_y_d;
    logic           fb_we_q,      fb_we_d;
    logic [15:0]    fb_addr_q,    fb_addr_d;
    logic [B-1:0]   fb_data_q,    fb_data_d;
    logic           fill_busy_q,  fill_busy_d;
    logic           fill_done_q,  fill_done_d;

    logic [7:0]     cx0, cy0, cx1, cy1;
    logic           pix_in_range;
    logic           pix_grant;
    logic           fill_grant;
    logic           fill_last;

    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one
        // unassigned and no latch is inferred; blocking '=' is correct here.
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        x0_d        = x0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
        color_d     = color_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        fb_we_d     = 1'b0;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        px_ready    = 1'b0;
        pix_grant   = 1'b0;
        fill_grant  = 1'b0;

        cx0          = clamp(fill_x0, X_MAX);
        cy0          = clamp(fill_y0, Y_MAX);
        cx1          = clamp(fill_x1, X_MAX);
        cy1          = clamp(fill_y1, Y_MAX);
        pix_in_range = ({1'b0, px_x} < 9'(W)) && ({1'b0, px_y} < 9'(H));
        fill_last    = (cur_x_q == x1_q) && (cur_y_q == y1_q);

        case (state_q)
            S_IDLE: begin
                px_ready  = 1'b1;
                pix_grant = px_valid;
                if (fill_start) begin
                    x0_d    = cx0;
                    x1_d    = cx1;
                    y1_d    = cy1;
                    color_d = fill_color;
                    cur_x_d = cx0;
                    cur_y_d = cy0;
                    // An empty rectangle completes without a single write.
                    state_d = ((cx0 <= cx1) && (cy0 <= cy1)) ? S_FILL : S_DONE;
                end
            end

            S_FILL: begin
                if (px_valid) begin
                    // Contended: whoever did not win last time wins now.
                    if (last_gnt_q == GNT_FILL) begin
                        pix_grant  = 1'b1;
                        last_gnt_d = GNT_PIX;
                    end else begin
                        fill_grant = 1'b1;
                        last_gnt_d = GNT_FILL;
                    end
                end else begin
                    fill_grant = 1'b1;
                end
                px_ready = pix_grant;

                if (fill_grant) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = addr_of(cur_x_q, cur_y_q);
                    fb_data_d = color_q;
                    if (fill_last) begin
                        state_d = S_DONE;
                    end else if (cur_x_q == x1_q) begin
                        cur_x_d = x0_q;
                        cur_y_d = cur_y_q + 8'd1;
                    end else begin
                        cur_x_d = cur_x_q + 8'd1;
                    end
                end
            end

            S_DONE: begin
                px_ready  = 1'b1;
                pix_grant = px_valid;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An accepted out-of-range pixel still consumes its grant but writes nothing.
        if (pix_grant && pix_in_range) begin
            fb_we_d   = 1'b1;
            fb_addr_d = addr_of(px_x, px_y);
            fb_data_d = px_data;
        end

        // Status flags are registered copies of the next state.
        fill_busy_d = (state_d == S_FILL);
        fill_done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in) begin
        // NOTE: reset is synchronous and has priority, so anything granted in
        // the reset cycle is discarded; sequential state uses '<=' only.
        if (rst_in) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= GNT_FILL;
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            color_q     <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            fill_busy_q <= 1'b0;
            fill_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            color_q     <= color_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            fill_busy_q <= fill_busy_d;
            fill_done_q <= fill_done_d;
        end
    end

    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    assign fb_data   = fb_data_q;
    assign fill_busy = fill_busy_q;
    assign fill_done = fill_done_q;

endmodule
